axis_display_timing_out: RTL and testbench
==========================================

Name: axis_display_timing_out

Overview:
Downstream consumer of the framebuffer reader's display stream. Converts a 16-bit RGB565 AXI-Stream (one pixel per beat, tlast on the final pixel of a frame) into a raster video interface: de, hsync, vsync and 8-bit RGB, suitable for a DVI/VGA encoder. Generates raster timing from parameters. Pulses frame_req at the start of vertical blanking so the frame-swap logic can request the next frame. Detects stream underflow and frame misalignment, and resynchronises on tlast.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch in clocks
H_SYNC, 96, hsync width in clocks
H_BP, 48, horizontal back porch in clocks
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch in lines
V_SYNC, 2, vsync width in lines
V_BP, 33, vertical back porch in lines
HSYNC_POL, 0, hsync active level
VSYNC_POL, 0, vsync active level
STREAM_WIDTH, 16, input tdata width; only 16 (RGB565) is supported

Ports:
aclk  in  1  pixel clock
resetn  in  1  reset, synchronous, active-low
s_axis_tvalid  in  1  pixel valid
s_axis_tready  out  1  pixel accepted
s_axis_tlast  in  1  last pixel of frame
s_axis_tdata  in  16  RGB565 pixel: [15:11] R, [10:5] G, [4:0] B
frame_req  out  1  one-cycle pulse at start of vertical blank
vid_de  out  1  data enable
vid_hsync  out  1  horizontal sync
vid_vsync  out  1  vertical sync
vid_rgb  out  24  {R8,G8,B8}
underflow  out  1  sticky: active pixel had no valid beat
misalign  out  1  sticky: tlast early or missing
clear_err  in  1  clears underflow and misalign

Behaviour:
- Counters: h_cnt runs 0..H_total-1 and v_cnt runs 0..V_total-1, where H_total = H_ACTIVE+H_FP+H_SYNC+H_BP (V_total likewise). Widths are $clog2 of the totals. Active region is h_cnt < H_ACTIVE and v_cnt < V_ACTIVE. Sync is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync uses the same rule on v_cnt.
- All vid_* outputs are registered, with one clock latency from the counter state. Sync outputs are driven at the polarity given by HSYNC_POL/VSYNC_POL.
- Reset: h_cnt=0, v_cnt=0, state=WAIT_FRAME, vid_de=0, vid_rgb=0, syncs inactive, frame_req=0, s_axis_tready=0, underflow=0, misalign=0.
- States:
  - WAIT_FRAME: stream not consumed (tready=0) and active pixels output black. Transition to ACTIVE when h_cnt=H_total-1 and v_cnt=V_total-1, i.e. the next cycle is pixel (0,0).
  - ACTIVE:
    - tready = active region.
    - tvalid=1 in active region: pixel output with de=1.
    - tvalid=0 in active region: black pixel, de=1, underflow set.
    - tlast accepted before pixel (H_ACTIVE-1, V_ACTIVE-1): misalign set; the remaining active pixels of this frame are black and unconsumed; go to WAIT_FRAME.
    - At the last active pixel with a beat accepted and tlast=0: misalign set; go to RESYNC.
    - At the last active pixel with tlast=1: stay in ACTIVE, start of next frame.
    - Last active pixel underflowed: go to RESYNC.
  - RESYNC: tready=1 during blanking only; beats are discarded until one with tlast=1 is accepted, then go to WAIT_FRAME. If still unsynced at the next active region, output black, tready=0, and keep waiting.
- frame_req is a single-cycle pulse when h_cnt=0 and v_cnt=V_ACTIVE, in every state.
- RGB expansion: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
- clear_err in the same cycle as a new error event: set wins.
- Reset mid-frame: counters restart at 0,0 and any partially received frame is abandoned. The upstream reader must also be reset.

Optional Feature:
TEST_PATTERN_EN
- Defined: adds input port test_pattern (1 bit). When high, active pixels show 8 vertical colour bars of width H_ACTIVE/8. Bar order: white, yellow, cyan, green, magenta, red, blue, black. tready is forced to 0, error flags are not updated, and the state machine holds. Deasserting test_pattern enters WAIT_FRAME.
- Undefined: the port is absent and the stream path only.

Decomposition:
- Package display_timing_pkg: state enum (WAIT_FRAME, ACTIVE, RESYNC), rgb565_to_rgb888 function, colour-bar constants, and the default 640x480@60 timing constants.
- Sub-module video_timing_gen: counters, sync/de/active flags, frame_req, last-active-pixel flag.
- Top level: stream handshake, state machine, error flags, output registers.

Test Plan:
- H_ACTIVE=4, V_ACTIVE=2, all porches and syncs 1. Source supplies 8 beats 0xF800 with tlast on beat 8, continuously. After the first WAIT_FRAME, each frame shows 8 de cycles of rgb 0xFF0000; underflow and misalign stay 0; frame_req pulses once per frame at v_cnt=2, h_cnt=0.
- Same timing; source stalls 1 cycle mid-frame. One de cycle outputs 0x000000 and underflow=1. The following frames realign via RESYNC.
- tlast on beat 5 of 8: misalign=1, pixels 6-8 black, tready=0 until the next frame start, then normal output resumes.
- tlast missing, source sends 12 beats with tlast on beat 12: misalign=1, beats 9-12 drained in blanking, next full frame displayed correctly.
- Pixel 0x07E0 gives 0x00FF00; pixel 0x001F gives 0x0000FF; pixel 0x8410 gives 0x848284.
- With TEST_PATTERN_EN defined and test_pattern=1, H_ACTIVE=16: pixels 0-1 are 0xFFFFFF and pixels 2-3 are 0xFFFF00; s_axis_tready stays 0 throughout.

Source files
------------

// File: rtl/display_timing_pkg.sv
// Shared types and helpers for the AXI-Stream to raster video output path.
package display_timing_pkg;

  typedef enum logic [1:0] {StWaitFrame, StActive, StResync} disp_state_e;

  // 640x480@60 default raster
  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;

  localparam logic [23:0] ColWhite   = 24'hFFFFFF;
  localparam logic [23:0] ColYellow  = 24'hFFFF00;
  localparam logic [23:0] ColCyan    = 24'h00FFFF;
  localparam logic [23:0] ColGreen   = 24'h00FF00;
  localparam logic [23:0] ColMagenta = 24'hFF00FF;
  localparam logic [23:0] ColRed     = 24'hFF0000;
  localparam logic [23:0] ColBlue    = 24'h0000FF;
  localparam logic [23:0] ColBlack   = 24'h000000;

  // Replicate MSBs into the low bits so full-scale 565 maps to full-scale 888.
  function automatic logic [23:0] rgb565_to_rgb888(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = ColWhite;
      3'd1:    c = ColYellow;
      3'd2:    c = ColCyan;
      3'd3:    c = ColGreen;
      3'd4:    c = ColMagenta;
      3'd5:    c = ColRed;
      3'd6:    c = ColBlue;
      default: c = ColBlack;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster counters with active, sync, frame-boundary flags and the frame_req pulse.
module video_timing_gen
  import display_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp,
  localparam int unsigned HTotal  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned VTotal  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HW      = $clog2(HTotal),
  localparam int unsigned VW      = $clog2(VTotal)
) (
  input  logic          aclk,
  input  logic          resetn,
  output logic [HW-1:0] h_cnt_o,
  output logic          active_o,
  output logic          hsync_act_o,
  output logic          vsync_act_o,
  output logic          frame_end_o,
  output logic          last_active_o,
  output logic          frame_req_o
);

  localparam logic [HW-1:0] HActEnd   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HActLast  = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HSyncBeg  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HSyncLast = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] HLast     = HW'(HTotal - 1);
  localparam logic [VW-1:0] VActEnd   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VActLast  = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VSyncBeg  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VSyncLast = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] VLast     = VW'(VTotal - 1);

  logic [HW-1:0] h_cnt_q;
  logic [VW-1:0] v_cnt_q;
  logic          frame_req_q;

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_req_q <= 1'b0;
    end else begin
      frame_req_q <= (h_cnt_q == '0) && (v_cnt_q == VActEnd);
      if (h_cnt_q == HLast) begin
        h_cnt_q <= '0;
        v_cnt_q <= (v_cnt_q == VLast) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_q <= h_cnt_q + 1'b1;
      end
    end
  end

  assign h_cnt_o       = h_cnt_q;
  assign active_o      = (h_cnt_q < HActEnd) && (v_cnt_q < VActEnd);
  assign hsync_act_o   = (h_cnt_q >= HSyncBeg) && (h_cnt_q <= HSyncLast);
  assign vsync_act_o   = (v_cnt_q >= VSyncBeg) && (v_cnt_q <= VSyncLast);
  assign frame_end_o   = (h_cnt_q == HLast) && (v_cnt_q == VLast);
  assign last_active_o = (h_cnt_q == HActLast) && (v_cnt_q == VActLast);
  assign frame_req_o   = frame_req_q;

endmodule

// File: rtl/axis_display_timing_out.sv
// RGB565 AXI-Stream to raster video with underflow/misalign detection.
// Optional build macro TEST_PATTERN_EN adds a test_pattern input selecting colour bars.
module axis_display_timing_out
  import display_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = DefHActive,
  parameter int unsigned H_FP         = DefHFp,
  parameter int unsigned H_SYNC       = DefHSync,
  parameter int unsigned H_BP         = DefHBp,
  parameter int unsigned V_ACTIVE     = DefVActive,
  parameter int unsigned V_FP         = DefVFp,
  parameter int unsigned V_SYNC       = DefVSync,
  parameter int unsigned V_BP         = DefVBp,
  parameter bit          HSYNC_POL    = 1'b0,
  parameter bit          VSYNC_POL    = 1'b0,
  parameter int unsigned STREAM_WIDTH = 16
) (
  input  logic                    aclk,
  input  logic                    resetn,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [STREAM_WIDTH-1:0] s_axis_tdata,
  output logic                    frame_req,
  output logic                    vid_de,
  output logic                    vid_hsync,
  output logic                    vid_vsync,
  output logic [23:0]             vid_rgb,
  output logic                    underflow,
  output logic                    misalign,
  input  logic                    clear_err
`ifdef TEST_PATTERN_EN
  ,
  input  logic                    test_pattern
`endif
);

  localparam int unsigned HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);

  logic [HW-1:0] h_cnt;
  logic          active, hsync_act, vsync_act, frame_end, last_active;
  logic          tp, tready, accept, uf_set, ma_set;
  logic [2:0]    bar_idx;
  logic [23:0]   rgb_d;
  disp_state_e   state_q, state_d;
  logic          de_q, hsync_q, vsync_q, uf_q, ma_q;
  logic [23:0]   rgb_q;

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .aclk          (aclk),
    .resetn        (resetn),
    .h_cnt_o       (h_cnt),
    .active_o      (active),
    .hsync_act_o   (hsync_act),
    .vsync_act_o   (vsync_act),
    .frame_end_o   (frame_end),
    .last_active_o (last_active),
    .frame_req_o   (frame_req)
  );

`ifdef TEST_PATTERN_EN
  logic tp_q;
  assign tp = test_pattern;
  always_ff @(posedge aclk) begin
    if (!resetn) tp_q <= 1'b0;
    else         tp_q <= test_pattern;
  end
`else
  assign tp = 1'b0;
`endif

  // Scaled before dividing so narrow test rasters never divide by zero.
  assign bar_idx = 3'((32'(h_cnt) << 3) / H_ACTIVE);

  always_comb begin
    tready = 1'b0;
    unique case (state_q)
      StActive: tready = active;
      StResync: tready = !active;
      default:  tready = 1'b0;
    endcase
    if (tp) tready = 1'b0;
  end

  assign s_axis_tready = tready;
  assign accept        = s_axis_tvalid && tready;

  always_comb begin
    state_d = state_q;
    uf_set  = 1'b0;
    ma_set  = 1'b0;
    unique case (state_q)
      StWaitFrame: if (frame_end) state_d = StActive;
      StActive: begin
        if (active) begin
          if (!s_axis_tvalid) begin
            uf_set = 1'b1;
            if (last_active) state_d = StResync;
          end else if (last_active) begin
            if (!s_axis_tlast) begin
              ma_set  = 1'b1;
              state_d = StResync;
            end
          end else if (s_axis_tlast) begin
            ma_set  = 1'b1;
            state_d = StWaitFrame;
          end
        end
      end
      StResync: begin
        if (accept && s_axis_tlast) state_d = frame_end ? StActive : StWaitFrame;
      end
      default: state_d = StWaitFrame;
    endcase
`ifdef TEST_PATTERN_EN
    if (test_pattern) begin
      state_d = state_q;
      uf_set  = 1'b0;
      ma_set  = 1'b0;
    end else if (tp_q) begin
      state_d = StWaitFrame;
    end
`endif
  end

  always_comb begin
    rgb_d = ColBlack;
    if (active) begin
      if (tp) rgb_d = bar_colour(bar_idx);
      else if (state_q == StActive && s_axis_tvalid) rgb_d = rgb565_to_rgb888(s_axis_tdata[15:0]);
    end
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_q <= StWaitFrame;
      de_q    <= 1'b0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      rgb_q   <= '0;
      uf_q    <= 1'b0;
      ma_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      de_q    <= active;
      hsync_q <= hsync_act ? HSYNC_POL : ~HSYNC_POL;
      vsync_q <= vsync_act ? VSYNC_POL : ~VSYNC_POL;
      rgb_q   <= rgb_d;
      uf_q    <= uf_set | (uf_q & ~clear_err);
      ma_q    <= ma_set | (ma_q & ~clear_err);
    end
  end

  assign vid_de    = de_q;
  assign vid_hsync = hsync_q;
  assign vid_vsync = vsync_q;
  assign vid_rgb   = rgb_q;
  assign underflow = uf_q;
  assign misalign  = ma_q;

endmodule

// File: tb/tb_axis_display_timing_out.sv
// Directed bench for axis_display_timing_out on a 4x2 active raster (7x5 total).
module tb_axis_display_timing_out;

  localparam logic [23:0] Red   = 24'hFF0000;
  localparam logic [23:0] Green = 24'h00FF00;
  localparam logic [23:0] Blue  = 24'h0000FF;
  localparam logic [23:0] Grey  = 24'h848284;

  typedef struct packed {
    logic        stall;
    logic        last;
    logic [15:0] data;
  } beat_t;

  logic        aclk = 1'b0;
  logic        resetn = 1'b0;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [15:0] s_axis_tdata;
  logic        frame_req, vid_de, vid_hsync, vid_vsync, underflow, misalign;
  logic [23:0] vid_rgb;
  logic        clear_err = 1'b0;
`ifdef TEST_PATTERN_EN
  logic        test_pattern = 1'b0;
`endif

  beat_t src_q[$];

  int n_vec = 0, n_err = 0;
  logic [23:0] pix [8][8];
  int n_de [8], hs_n [8], vs_n [8], req_lat [8], gap [8];
  int fi = 0, cur_n = 0, hs = 0, vs = 0, cyc = 0, last_de = 0, prev_req = 0;

  always #5 aclk = ~aclk;

  axis_display_timing_out #(
    .H_ACTIVE  (4),
    .H_FP      (1),
    .H_SYNC    (1),
    .H_BP      (1),
    .V_ACTIVE  (2),
    .V_FP      (1),
    .V_SYNC    (1),
    .V_BP      (1),
    .HSYNC_POL (1'b0),
    .VSYNC_POL (1'b0)
  ) dut (
    .aclk          (aclk),
    .resetn        (resetn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tdata  (s_axis_tdata),
    .frame_req     (frame_req),
    .vid_de        (vid_de),
    .vid_hsync     (vid_hsync),
    .vid_vsync     (vid_vsync),
    .vid_rgb       (vid_rgb),
    .underflow     (underflow),
    .misalign      (misalign),
    .clear_err     (clear_err)
`ifdef TEST_PATTERN_EN
    ,
    .test_pattern  (test_pattern)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Source: one queue entry per ready cycle; stall entries present tvalid=0 for that cycle.
  initial begin
    bit    fire = 1'b0;
    beat_t b;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    forever begin
      @(negedge aclk);
      if (fire && resetn && src_q.size() > 0) b = src_q.pop_front();
      if (src_q.size() > 0) begin
        b = src_q[0];
        s_axis_tvalid = !b.stall;
        s_axis_tlast  = b.last;
        s_axis_tdata  = b.data;
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
      end
      fire = resetn && s_axis_tready && (src_q.size() > 0);
    end
  end

  // Monitor: one record per frame, closed by each frame_req pulse.
  initial begin
    forever begin
      @(negedge aclk);
      cyc++;
      if (!resetn) begin
        fi = 0; cur_n = 0; hs = 0; vs = 0;
      end else begin
        if (vid_de) begin
          if (cur_n < 8 && fi < 8) pix[fi][cur_n] = vid_rgb;
          cur_n++;
          last_de = cyc;
        end
        if (!vid_hsync) hs++;
        if (!vid_vsync) vs++;
        if (frame_req) begin
          if (fi < 8) begin
            n_de[fi] = cur_n; hs_n[fi] = hs; vs_n[fi] = vs;
            req_lat[fi] = cyc - last_de;
            gap[fi] = cyc - prev_req;
          end
          prev_req = cyc;
          fi++; cur_n = 0; hs = 0; vs = 0;
        end
      end
    end
  end

  function automatic int count_px(input int f, input logic [23:0] v);
    int c = 0;
    for (int i = 0; i < 8; i++) if (pix[f][i] == v) c++;
    return c;
  endfunction

  task automatic push_beats(input int n, input logic [15:0] data, input int last_at,
                            input int stall_at);
    beat_t b;
    for (int i = 1; i <= n; i++) begin
      if (i == stall_at) begin
        b = '{stall: 1'b1, last: 1'b0, data: 16'h0};
        src_q.push_back(b);
      end
      b = '{stall: 1'b0, last: (i == last_at), data: data};
      src_q.push_back(b);
    end
  endtask

  task automatic do_reset();
    @(posedge aclk); #2;
    resetn = 1'b0; clear_err = 1'b0;
    src_q.delete();
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) pix[i][j] = 24'h5A5A5A;
    repeat (3) @(posedge aclk);
    #2 resetn = 1'b1;
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (fi < n && t < 1000) begin
      @(negedge aclk);
      t++;
    end
    check("frames_seen", 32'(fi >= n), 1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge aclk);
    check("rst_de", vid_de, 0);
    check("rst_rgb", vid_rgb, 0);
    check("rst_hsync", vid_hsync, 1);
    check("rst_vsync", vid_vsync, 1);
    check("rst_frame_req", frame_req, 0);
    check("rst_tready", s_axis_tready, 0);
    check("rst_underflow", underflow, 0);
    check("rst_misalign", misalign, 0);

    // Continuous red frames
    do_reset();
    for (int k = 0; k < 5; k++) push_beats(8, 16'hF800, 8, 0);
    wait_frames(4);
    check("s1_f0_de", n_de[0], 8);
    check("s1_f0_black", count_px(0, 24'h0), 8);
    check("s1_f1_de", n_de[1], 8);
    check("s1_f1_red", count_px(1, Red), 8);
    check("s1_f3_red", count_px(3, Red), 8);
    check("s1_req_lat", req_lat[1], 4);
    check("s1_req_gap", gap[2], 35);
    check("s1_hsync_cnt", hs_n[2], 5);
    check("s1_vsync_cnt", vs_n[2], 7);
    check("s1_underflow", underflow, 0);
    check("s1_misalign", misalign, 0);

    // One-cycle stall before beat 5
    do_reset();
    push_beats(8, 16'hF800, 8, 5);
    push_beats(8, 16'hF800, 8, 0);
    push_beats(8, 16'hF800, 8, 0);
    wait_frames(3);
    check("s2_f1_de", n_de[1], 8);
    check("s2_px4", pix[1][3], Red);
    check("s2_px5_black", pix[1][4], 0);
    check("s2_px6", pix[1][5], Red);
    check("s2_f1_red", count_px(1, Red), 7);
    check("s2_f2_red", count_px(2, Red), 8);
    check("s2_underflow", underflow, 1);

    // Early tlast on beat 5
    do_reset();
    push_beats(5, 16'h001F, 5, 0);
    push_beats(8, 16'h07E0, 8, 0);
    push_beats(8, 16'h07E0, 8, 0);
    wait_frames(3);
    check("s3_px5_blue", pix[1][4], Blue);
    check("s3_f1_blue", count_px(1, Blue), 5);
    check("s3_f1_black", count_px(1, 24'h0), 3);
    check("s3_px8_black", pix[1][7], 0);
    check("s3_f2_green", count_px(2, Green), 8);
    check("s3_misalign", misalign, 1);
    check("s3_underflow", underflow, 0);

    // Missing tlast: 12-beat frame drained in blanking
    do_reset();
    push_beats(8, 16'h8410, 0, 0);
    push_beats(4, 16'hFFFF, 4, 0);
    push_beats(8, 16'h07E0, 8, 0);
    push_beats(8, 16'h07E0, 8, 0);
    wait_frames(3);
    check("s4_f1_grey", count_px(1, Grey), 8);
    check("s4_f2_green", count_px(2, Green), 8);
    check("s4_misalign", misalign, 1);
    check("s4_underflow", underflow, 0);

    @(posedge aclk); #2 clear_err = 1'b1;
    @(posedge aclk); #2 clear_err = 1'b0;
    @(negedge aclk);
    check("clr_misalign", misalign, 0);
    check("clr_underflow", underflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
